// File: rtl/core_sequencer_pkg.sv
// Shared types and defaults for the multi-cycle core sequencer.
package core_sequencer_pkg;

    localparam int STATE_W         = 3;
    localparam int DEFAULT_AW      = 32;
    localparam int DEFAULT_PC_STEP = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction and data memory req/ack handshake bundle.
interface core_sequencer_if
    import core_sequencer_pkg::*;
#(
    parameter int AW = DEFAULT_AW
);

    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          dmem_req;
    logic          dmem_we;
    logic          dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );

endinterface

// File: rtl/core_sequencer_ret_addr_stack.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module ret_addr_stack #(
    parameter int AW        = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] top,
    output logic          empty,
    output logic          full,
    output logic          ovf_pulse
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem [RAS_DEPTH];
    logic [PW-1:0] sp;
    logic [CW-1:0] count;

    assign empty     = (count == '0);
    assign full      = (count == CW'(RAS_DEPTH));
    assign ovf_pulse = push & full;
    assign top       = mem[sp];

    // Pointer wraps naturally (power-of-2 depth), so a full push lands on the oldest slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp    <= '0;
            count <= '0;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            sp    <= '0;
            count <= '0;
        end else if (push) begin
            sp                 <= sp + PW'(1);
            mem[sp + PW'(1)]   <= din;
            if (!full) begin
                count <= count + CW'(1);
            end
        end else if (pop && !empty) begin
            sp    <= sp - PW'(1);
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle sequencer: owns the PC and steps FETCH/DECODE/EXEC/MEM/WB.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int            AW        = DEFAULT_AW,
    parameter int            RAS_DEPTH = 4,
    parameter logic [AW-1:0] RESET_PC  = '0,
    parameter int            PC_STEP   = DEFAULT_PC_STEP,
    parameter int            TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    core_sequencer_if.master     bus,
    output logic [31:0]          instruction,
    output logic [AW-1:0]        pc_current,
    input  logic                 isbranchtaken,
    input  logic [AW-1:0]        branchpc,
    input  logic                 iscall,
    input  logic                 isret,
    input  logic                 isid,
    input  logic                 isst,
    input  logic                 iswb,
    input  logic                 ishalt,
    output logic                 wb_en,
    output logic [AW-1:0]        ret_target,
    output logic [STATE_W-1:0]   state,
    output logic [31:0]          instret,
    output logic                 ras_ovf,
    output logic                 err
);

    localparam int            WCW       = (TIMEOUT > 15) ? $clog2(TIMEOUT + 1) : 4;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] pc, next_pc_q, next_pc_d;
    logic [WCW-1:0] wait_cnt;
    logic          ras_push, ras_pop, ras_clear;
    logic          ras_empty, ras_full, ras_ovf_pulse;
    logic [AW-1:0] ras_top;

    ret_addr_stack #(
        .AW        (AW),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .clear     (ras_clear),
        .din       (pc_current + AW'(PC_STEP)),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .ovf_pulse (ras_ovf_pulse)
    );

    // Requests derive from the state register only, so an async reset drops them at once.
    assign bus.imem_req  = (state_q == ST_FETCH);
    assign bus.imem_addr = pc;
    assign bus.dmem_req  = (state_q == ST_MEM);
    assign bus.dmem_we   = (state_q == ST_MEM) & isst;
    assign wb_en         = (state_q == ST_WB) & iswb;
    assign err           = (state_q == ST_ERROR);
    assign state         = state_q;
    assign ret_target    = ras_top;

    // Next-state, next-PC selection and stack control.
    always_comb begin
        state_d   = state_q;
        next_pc_d = pc + AW'(PC_STEP);
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        ras_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.imem_ack)               state_d = ST_DECODE;
                else if (wait_cnt == WAIT_LAST) state_d = ST_ERROR;
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (isret && (iscall || ras_empty)) begin
                    state_d = ST_ERROR;
                end else begin
                    if (isret) begin
                        next_pc_d = ras_top;
                        ras_pop   = 1'b1;
                    end else if (isbranchtaken) begin
                        next_pc_d = branchpc;
                    end
                    ras_push = iscall;
                    state_d  = (isid || isst) ? ST_MEM : ST_WB;
                end
            end
            ST_MEM: begin
                if (bus.dmem_ack)               state_d = ST_WB;
                else if (wait_cnt == WAIT_LAST) state_d = ST_ERROR;
            end
            ST_WB: state_d = ishalt ? ST_HALT : ST_FETCH;
            ST_HALT: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    ras_clear = 1'b1;
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Wait-cycle counter: runs while a FETCH or MEM request stays unacknowledged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if ((state_q == ST_FETCH || state_q == ST_MEM) && state_d == state_q) begin
            wait_cnt <= wait_cnt + WCW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // PC, latched instruction, retire count and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            pc_current  <= RESET_PC;
            next_pc_q   <= RESET_PC;
            instruction <= '0;
            instret     <= '0;
            ras_ovf     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HALT: begin
                    if (start) pc <= RESET_PC;
                end
                ST_FETCH: begin
                    if (bus.imem_ack) begin
                        instruction <= bus.imem_rdata;
                        pc_current  <= pc;
                    end
                end
                ST_EXEC: next_pc_q <= next_pc_d;
                ST_WB: begin
                    pc      <= next_pc_q;
                    instret <= instret + 32'd1;
                end
                default: ;
            endcase
            if (ras_ovf_pulse && ras_full) ras_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer against a queue-based program model.
module tb_core_sequencer;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int AW        = 32;
    localparam int RAS_DEPTH = 4;
    localparam int TIMEOUT   = 15;
    localparam int PC_STEP   = 4;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6, S_ERROR = 3'd7;

    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BRANCH = 3,
                   K_CALL = 4, K_RET = 5, K_HALT = 6, K_RETCALL = 7;

    logic          clk = 1'b0;
    logic          reset, start;
    logic          isbranchtaken, iscall, isret, isid, isst, iswb, ishalt;
    logic [AW-1:0] branchpc;
    logic [31:0]   instruction, instret;
    logic [AW-1:0] pc_current, ret_target;
    logic          wb_en, ras_ovf, err;
    logic [2:0]    state;

    core_sequencer_if #(.AW(AW)) bus ();

    core_sequencer #(
        .AW        (AW),
        .RAS_DEPTH (RAS_DEPTH),
        .RESET_PC  (32'h0),
        .PC_STEP   (PC_STEP),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .bus           (bus),
        .instruction   (instruction),
        .pc_current    (pc_current),
        .isbranchtaken (isbranchtaken),
        .branchpc      (branchpc),
        .iscall        (iscall),
        .isret         (isret),
        .isid          (isid),
        .isst          (isst),
        .iswb          (iswb),
        .ishalt        (ishalt),
        .wb_en         (wb_en),
        .ret_target    (ret_target),
        .state         (state),
        .instret       (instret),
        .ras_ovf       (ras_ovf),
        .err           (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural PC, retire count, return stack as a bounded queue.
    logic [AW-1:0] m_pc;
    logic [31:0]   m_instret;
    logic [AW-1:0] m_stack[$];
    logic          m_ovf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = '0;
        m_instret = '0;
        m_stack.delete();
        m_ovf     = 1'b0;
    endtask

    task automatic clear_inputs();
        start           = 1'b0;
        isbranchtaken   = 1'b0;
        iscall          = 1'b0;
        isret           = 1'b0;
        isid            = 1'b0;
        isst            = 1'b0;
        iswb            = 1'b0;
        ishalt          = 1'b0;
        branchpc        = '0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.dmem_ack    = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        #1;
        check("rst_state", state, S_IDLE);
        check("rst_imem_req", bus.imem_req, 1'b0);
        check("rst_dmem_req", bus.dmem_req, 1'b0);
        @(negedge clk);
        check("rst_wb_en", wb_en, 1'b0);
        check("rst_instret", instret, 32'd0);
        check("rst_ras_ovf", ras_ovf, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_instruction", instruction, 32'd0);
        check("rst_pc_current", pc_current, 32'd0);
        check("rst_imem_addr", bus.imem_addr, 32'd0);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge where FETCH is visible.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic restart_from_halt();
        check("halt_state", state, S_HALT);
        pulse_start();
        m_pc = '0;
        m_stack.delete();
    endtask

    // Runs one instruction from its first FETCH cycle; iw/dw are wait cycles before each ack.
    task automatic run_instr(input int kind, input int iw, input int dw,
                             input logic [AW-1:0] target, input logic taken, input logic wb);
        automatic logic [31:0]   word   = $urandom;
        automatic bit            is_mem = (kind == K_LOAD) || (kind == K_STORE);
        automatic bit            exp_err;
        automatic int            exp_lat;
        automatic int            fcnt   = 0;
        automatic int            dcnt   = 0;
        automatic bit            done   = 0;
        automatic bit            got_wb = 0;
        automatic logic [AW-1:0] exp_next;

        exp_err = (iw >= TIMEOUT) || (is_mem && dw >= TIMEOUT) || (kind == K_RETCALL) ||
                  (kind == K_RET && m_stack.size() == 0);
        exp_lat = 4 + iw + (is_mem ? 1 + dw : 0);

        isid          = (kind == K_LOAD);
        isst          = (kind == K_STORE);
        iscall        = (kind == K_CALL) || (kind == K_RETCALL);
        isret         = (kind == K_RET) || (kind == K_RETCALL);
        ishalt        = (kind == K_HALT);
        iswb          = wb;
        isbranchtaken = taken;
        branchpc      = target;

        check("fetch_req", bus.imem_req, 1'b1);
        check("fetch_addr", bus.imem_addr, m_pc);

        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            bus.imem_ack = 1'b0;
            bus.dmem_ack = 1'b0;
            case (state)
                S_FETCH: begin
                    bus.imem_ack   = (fcnt == iw);
                    bus.imem_rdata = word;
                    bus.dmem_ack   = 1'($urandom_range(0, 1));
                    fcnt++;
                end
                S_DECODE: begin
                    check("instruction", instruction, word);
                    check("pc_current", pc_current, m_pc);
                    bus.imem_ack = 1'($urandom_range(0, 1));
                    bus.dmem_ack = 1'($urandom_range(0, 1));
                end
                S_EXEC: begin
                    bus.imem_ack = 1'($urandom_range(0, 1));
                    bus.dmem_ack = 1'($urandom_range(0, 1));
                end
                S_MEM: begin
                    if (dcnt == 0) check("dmem_we", bus.dmem_we, kind == K_STORE);
                    bus.dmem_ack = (dcnt == dw);
                    bus.imem_ack = 1'($urandom_range(0, 1));
                    dcnt++;
                end
                S_WB: begin
                    check("wb_cycle", cyc, exp_lat);
                    check("wb_en", wb_en, wb);
                    bus.imem_ack = 1'($urandom_range(0, 1));
                    got_wb = 1;
                    done   = 1;
                end
                default: done = 1;
            endcase
            @(negedge clk);
        end
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;

        if (exp_err) begin
            check("err_state", state, S_ERROR);
            check("err_flag", err, 1'b1);
            check("err_imem_req", bus.imem_req, 1'b0);
            check("err_dmem_req", bus.dmem_req, 1'b0);
            check("err_no_wb", got_wb, 1'b0);
            if (iw >= TIMEOUT) check("fetch_wait_cycles", fcnt, TIMEOUT);
            if (is_mem && dw >= TIMEOUT) check("mem_wait_cycles", dcnt, TIMEOUT);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("err_start_ignored", state, S_ERROR);
        end else begin
            if (kind == K_RET)  exp_next = m_stack.pop_back();
            else if (taken)     exp_next = target;
            else                exp_next = m_pc + PC_STEP;
            if (kind == K_CALL) begin
                m_stack.push_back(m_pc + PC_STEP);
                if (m_stack.size() > RAS_DEPTH) begin
                    void'(m_stack.pop_front());
                    m_ovf = 1'b1;
                end
            end
            m_pc = exp_next;
            m_instret++;
            check("wb_reached", got_wb, 1'b1);
            check("wb_one_cycle", wb_en, 1'b0);
            check("instret", instret, m_instret);
            check("ras_ovf", ras_ovf, m_ovf);
            check("next_state", state, (kind == K_HALT) ? S_HALT : S_FETCH);
            if (m_stack.size() > 0) check("ret_target", ret_target, m_stack[m_stack.size() - 1]);
            if (kind != K_HALT) check("next_fetch_addr", bus.imem_addr, m_pc);
        end
    endtask

    task automatic reset_in_mem();
        automatic bit reached = 0;
        isid = 1'b1;
        iswb = 1'b1;
        for (int i = 0; i < 10 && !reached; i++) begin
            bus.imem_ack = (state == S_FETCH);
            if (state == S_MEM) reached = 1;
            else @(negedge clk);
        end
        bus.imem_ack = 1'b0;
        check("mem_reached", reached, 1'b1);
        @(negedge clk);
        check("mem_req_before_reset", bus.dmem_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("async_dmem_req", bus.dmem_req, 1'b0);
        check("async_state", state, S_IDLE);
        check("async_wb_en", wb_en, 1'b0);
        @(negedge clk);
        check("async_no_retire", instret, 32'd0);
        check("async_wb_en_later", wb_en, 1'b0);
        clear_inputs();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        automatic int            r, kind, iw, dw;
        automatic logic [AW-1:0] tgt;
        automatic logic          tk, wbv;

        clear_inputs();
        reset = 1'b0;
        model_reset();
        apply_reset();

        // Directed: ALU, delayed load, branch, call/ret.
        pulse_start();
        run_instr(K_ALU,    0, 0, '0,        1'b0, 1'b1);
        run_instr(K_LOAD,   2, 3, '0,        1'b0, 1'b1);
        run_instr(K_BRANCH, 0, 0, 32'h40,    1'b1, 1'b0);
        run_instr(K_CALL,   0, 0, 32'h100,   1'b1, 1'b1);
        run_instr(K_RET,    1, 0, 32'h999C,  1'b1, 1'b0);

        // Five nested calls overflow a 4-deep stack; the fifth ret finds it empty.
        for (int i = 0; i < 5; i++) run_instr(K_CALL, 0, 0, 32'h200 * (i + 1), 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) run_instr(K_RET, 0, 0, '0, 1'b0, 1'b0);
        apply_reset();

        // Randomized instruction stream.
        pulse_start();
        for (int i = 0; i < 150; i++) begin
            r   = $urandom_range(0, 99);
            iw  = $urandom_range(0, 3);
            dw  = $urandom_range(0, 3);
            tgt = $urandom & 32'hFFFF_FFFC;
            tk  = 1'($urandom_range(0, 1));
            wbv = 1'($urandom_range(0, 1));
            if      (r < 30) kind = K_ALU;
            else if (r < 45) kind = K_LOAD;
            else if (r < 55) kind = K_STORE;
            else if (r < 70) kind = K_BRANCH;
            else if (r < 82) kind = K_CALL;
            else if (r < 95) kind = (m_stack.size() > 0) ? K_RET : K_ALU;
            else             kind = K_HALT;
            if (kind == K_CALL) tk = 1'b1;
            if (kind == K_ALU || kind == K_HALT || kind == K_STORE) tk = 1'b0;
            if (kind == K_LOAD) wbv = 1'b1;
            if (kind == K_STORE || kind == K_HALT) wbv = 1'b0;
            run_instr(kind, iw, dw, tgt, tk, wbv);
            if (kind == K_HALT) restart_from_halt();
        end

        // PC wraps modulo 2^AW.
        run_instr(K_BRANCH, 0, 0, 32'hFFFF_FFFC, 1'b1, 1'b0);
        run_instr(K_ALU,    0, 0, '0,            1'b0, 1'b1);
        apply_reset();

        // Halt at 0xC, restart keeps instret.
        pulse_start();
        for (int i = 0; i < 3; i++) run_instr(K_ALU, 0, 0, '0, 1'b0, 1'b1);
        run_instr(K_HALT, 0, 0, '0, 1'b0, 1'b0);
        restart_from_halt();
        run_instr(K_ALU, 0, 0, '0, 1'b0, 1'b1);
        apply_reset();

        // Fetch timeout, memory timeout, illegal ret+call.
        pulse_start();
        run_instr(K_ALU, 99, 0, '0, 1'b0, 1'b1);
        apply_reset();
        pulse_start();
        run_instr(K_STORE, 0, 99, '0, 1'b0, 1'b0);
        apply_reset();
        pulse_start();
        run_instr(K_CALL, 0, 0, 32'h80, 1'b1, 1'b1);
        run_instr(K_RETCALL, 0, 0, 32'h40, 1'b1, 1'b0);
        apply_reset();

        // Async reset while waiting in MEM.
        pulse_start();
        reset_in_mem();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
